// File: rtl/auth_initiator_pkg.sv
// -----------------------------------------------------------------------------
// auth_initiator_pkg
//   Shared authentication constants and types: message sizing, header layout,
//   MessageType codes, USB control-transfer fields, completion codes, response
//   timeouts (in clock cycles) and the one-hot FSM state encoding.
// -----------------------------------------------------------------------------
package auth_initiator_pkg;

   localparam int AUTH_MSG_LEN = 1024;   // header + payload, bits
   localparam int AUTH_HDR_W   = 32;     // header field size, bits

   localparam logic [7:0] AUTH_VERSION = 8'h01;

   // Request MessageTypes
   localparam logic [7:0] MT_GET_DIGESTS     = 8'h81;
   localparam logic [7:0] MT_GET_CERTIFICATE = 8'h82;
   localparam logic [7:0] MT_CHALLENGE       = 8'h83;
   // Response MessageTypes
   localparam logic [7:0] MT_DIGESTS         = 8'h01;
   localparam logic [7:0] MT_CERTIFICATE     = 8'h02;
   localparam logic [7:0] MT_CHALLENGE_AUTH  = 8'h03;
   localparam logic [7:0] MT_ERROR           = 8'h7F;
   // ERROR Param1 value meaning "responder busy, try again"
   localparam logic [7:0] ERR_PARAM_BUSY     = 8'h03;

   // USB control-transfer fields
   localparam logic [7:0]  USB_BM_REQUEST_TYPE = 8'h00;
   localparam logic [7:0]  USB_B_REQUEST       = 8'd25;
   localparam logic [15:0] WLEN_DIGESTS        = 16'd4;
   localparam logic [15:0] WLEN_CERTIFICATE    = 16'd8;
   localparam logic [15:0] WLEN_CHALLENGE      = 16'd36;

   // Response timeouts, in clock cycles spent in WAIT_RESP
   localparam logic [15:0] DIGEST_ANW_TIMEOUT      = 16'd16;
   localparam logic [15:0] CERTIFICATE_ANW_TIMEOUT = 16'd24;
   localparam logic [15:0] CHALLENGE_TIMEOUT_AUTH  = 16'd32;

   typedef enum logic [1:0] {
      RT_GET_DIGESTS     = 2'd0,
      RT_GET_CERTIFICATE = 2'd1,
      RT_CHALLENGE       = 2'd2,
      RT_INVALID         = 2'd3
   } req_type_e;

   typedef enum logic [2:0] {
      ERR_NONE       = 3'd0,
      ERR_TIMEOUT    = 3'd1,
      ERR_VERSION    = 3'd2,
      ERR_UNEXPECTED = 3'd3,
      ERR_RESPONDER  = 3'd4,
      ERR_BAD_REQ    = 3'd5
   } err_code_e;

   typedef enum logic [4:0] {
      S_IDLE       = 5'b00001,
      S_SEND_REQ   = 5'b00010,
      S_WAIT_RESP  = 5'b00100,
      S_CHECK_RESP = 5'b01000,
      S_DONE       = 5'b10000
   } fsm_state_e;

   typedef struct packed {
      logic [7:0] version;
      logic [7:0] msg_type;
      logic [7:0] param1;
      logic [7:0] param2;
   } auth_hdr_t;

   function automatic logic [7:0] req_msg_type(input logic [1:0] rt);
      case (rt)
         2'd0:    return MT_GET_DIGESTS;
         2'd1:    return MT_GET_CERTIFICATE;
         default: return MT_CHALLENGE;
      endcase
   endfunction

   function automatic logic [7:0] resp_msg_type(input logic [1:0] rt);
      case (rt)
         2'd0:    return MT_DIGESTS;
         2'd1:    return MT_CERTIFICATE;
         default: return MT_CHALLENGE_AUTH;
      endcase
   endfunction

   function automatic logic [15:0] resp_timeout(input logic [1:0] rt);
      case (rt)
         2'd0:    return DIGEST_ANW_TIMEOUT;
         2'd1:    return CERTIFICATE_ANW_TIMEOUT;
         default: return CHALLENGE_TIMEOUT_AUTH;
      endcase
   endfunction

endpackage

// File: rtl/auth_req_builder.sv
// -----------------------------------------------------------------------------
// auth_req_builder
//   Purely combinational formatter for an outgoing auth request.
//   i_req_type / i_slot / i_payload : latched request (req_type 0..2)
//   o_msg                           : {header, payload}, header in the MSBs
//   o_bm_request_type, o_b_request,
//   o_w_length                      : USB control-transfer fields
// -----------------------------------------------------------------------------
module auth_req_builder
   import auth_initiator_pkg::*;
#(
   parameter int MSG_LEN = AUTH_MSG_LEN
) (
   input  logic [1:0]                    i_req_type,
   input  logic [1:0]                    i_slot,
   input  logic [MSG_LEN-AUTH_HDR_W-1:0] i_payload,
   output logic [MSG_LEN-1:0]            o_msg,
   output logic [7:0]                    o_bm_request_type,
   output logic [7:0]                    o_b_request,
   output logic [15:0]                   o_w_length
);

   auth_hdr_t w_hdr;

   always_comb begin
      w_hdr.version  = AUTH_VERSION;
      w_hdr.msg_type = req_msg_type(i_req_type);
      w_hdr.param1   = {6'b0, i_slot};
      w_hdr.param2   = 8'h00;

      o_msg             = {w_hdr, i_payload};
      o_bm_request_type = USB_BM_REQUEST_TYPE;
      o_b_request       = USB_B_REQUEST;
      case (i_req_type)
         2'd0:    o_w_length = WLEN_DIGESTS;
         2'd1:    o_w_length = WLEN_CERTIFICATE;
         default: o_w_length = WLEN_CHALLENGE;
      endcase
   end

endmodule

// File: rtl/auth_initiator.sv
// -----------------------------------------------------------------------------
// auth_initiator
//   Requester side of a GET_DIGESTS / GET_CERTIFICATE / CHALLENGE exchange
//   with timeout and bounded Busy-retry handling.
//   clk, reset (async, active-high)
//   start, req_type, slot, req_payload : request launch (sampled in IDLE)
//   init_req_out, auth_msg_req_out,
//   bmRequestType, bRequest, wLength   : request presentation (SEND_REQ only)
//   Ack_in                             : transport accepted the request
//   resp_valid_in, auth_msg_resp_in    : responder message
//   busy, done, error_code,
//   resp_header, resp_payload          : completion status / captured response
// -----------------------------------------------------------------------------
module auth_initiator
   import auth_initiator_pkg::*;
#(
   parameter int MSG_LEN   = AUTH_MSG_LEN,
   parameter int MAX_RETRY = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [1:0]                    req_type,
   input  logic [1:0]                    slot,
   input  logic [MSG_LEN-AUTH_HDR_W-1:0] req_payload,
   output logic                          init_req_out,
   output logic [MSG_LEN-1:0]            auth_msg_req_out,
   output logic [7:0]                    bmRequestType,
   output logic [7:0]                    bRequest,
   output logic [15:0]                   wLength,
   input  logic                          Ack_in,
   input  logic                          resp_valid_in,
   input  logic [MSG_LEN-1:0]            auth_msg_resp_in,
   output logic                          busy,
   output logic                          done,
   output logic [2:0]                    error_code,
   output logic [AUTH_HDR_W-1:0]         resp_header,
   output logic [MSG_LEN-AUTH_HDR_W-1:0] resp_payload
);

   localparam int         PL_W         = MSG_LEN - AUTH_HDR_W;
   localparam logic [7:0] LP_MAX_RETRY = 8'(MAX_RETRY);

   fsm_state_e              r_state, w_state_nxt;
   logic [1:0]              r_req_type, r_slot;
   logic [PL_W-1:0]         r_payload;
   logic [7:0]              r_retry;
   logic [15:0]             r_cnt;
   logic [2:0]              r_err;
   logic [AUTH_HDR_W-1:0]   r_resp_hdr;
   logic [PL_W-1:0]         r_resp_pl;

   auth_hdr_t               w_hdr;
   logic [2:0]              w_check_code;
   logic                    w_retry_go;
   logic                    w_timeout;
   logic [MSG_LEN-1:0]      w_msg;
   logic [7:0]              w_bm, w_breq;
   logic [15:0]             w_wlen;

   auth_req_builder #(.MSG_LEN(MSG_LEN)) u_builder (
      .i_req_type        (r_req_type),
      .i_slot            (r_slot),
      .i_payload         (r_payload),
      .o_msg             (w_msg),
      .o_bm_request_type (w_bm),
      .o_b_request       (w_breq),
      .o_w_length        (w_wlen)
   );

   // Final WAIT_RESP cycle: counter has reached limit-1.
   assign w_timeout = (r_cnt == resp_timeout(r_req_type) - 16'd1);

   // Classification of the captured response, used while in CHECK_RESP.
   always_comb begin
      w_hdr        = r_resp_hdr;
      w_check_code = ERR_NONE;
      w_retry_go   = 1'b0;
      if (w_hdr.version != AUTH_VERSION)
         w_check_code = ERR_VERSION;
      else if (w_hdr.msg_type == resp_msg_type(r_req_type))
         w_check_code = ERR_NONE;
      else if (w_hdr.msg_type == MT_ERROR) begin
         if (w_hdr.param1 == ERR_PARAM_BUSY && r_retry < LP_MAX_RETRY)
            w_retry_go = 1'b1;
         else
            w_check_code = ERR_RESPONDER;
      end else
         w_check_code = ERR_UNEXPECTED;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:
            if (start) w_state_nxt = (req_type == RT_INVALID) ? S_DONE : S_SEND_REQ;
         S_SEND_REQ:
            if (Ack_in) w_state_nxt = S_WAIT_RESP;
         S_WAIT_RESP:
            // A response on the final cycle takes priority over the timeout.
            if (resp_valid_in)  w_state_nxt = S_CHECK_RESP;
            else if (w_timeout) w_state_nxt = S_DONE;
         S_CHECK_RESP:
            w_state_nxt = w_retry_go ? S_SEND_REQ : S_DONE;
         S_DONE:
            w_state_nxt = S_IDLE;
         default:
            w_state_nxt = S_IDLE;
      endcase
   end

   // Request latch, counters, status and response capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_req_type <= '0;
         r_slot     <= '0;
         r_payload  <= '0;
         r_retry    <= '0;
         r_cnt      <= '0;
         r_err      <= '0;
         r_resp_hdr <= '0;
         r_resp_pl  <= '0;
      end else begin
         case (r_state)
            S_IDLE:
               if (start) begin
                  if (req_type == RT_INVALID) begin
                     r_err <= ERR_BAD_REQ;
                  end else begin
                     r_req_type <= req_type;
                     r_slot     <= slot;
                     r_payload  <= req_payload;
                     r_retry    <= '0;
                     r_err      <= ERR_NONE;
                  end
               end
            S_SEND_REQ:
               if (Ack_in) r_cnt <= '0;
            S_WAIT_RESP:
               if (resp_valid_in) begin
                  r_resp_hdr <= auth_msg_resp_in[MSG_LEN-1 -: AUTH_HDR_W];
                  r_resp_pl  <= auth_msg_resp_in[PL_W-1:0];
               end else if (w_timeout) begin
                  r_err <= ERR_TIMEOUT;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            S_CHECK_RESP:
               if (w_retry_go) r_retry <= r_retry + 8'd1;
               else            r_err   <= w_check_code;
            default: ;
         endcase
      end
   end

   // Outputs; request fields are driven only while the request is presented.
   always_comb begin
      busy             = (r_state != S_IDLE);
      done             = (r_state == S_DONE);
      init_req_out     = (r_state == S_SEND_REQ);
      auth_msg_req_out = '0;
      bmRequestType    = '0;
      bRequest         = '0;
      wLength          = '0;
      if (r_state == S_SEND_REQ) begin
         auth_msg_req_out = w_msg;
         bmRequestType    = w_bm;
         bRequest         = w_breq;
         wLength          = w_wlen;
      end
      error_code   = r_err;
      resp_header  = r_resp_hdr;
      resp_payload = r_resp_pl;
   end

endmodule

// File: tb/tb_auth_initiator.sv
module tb_auth_initiator;
   import auth_initiator_pkg::*;

   localparam int L  = 1024;
   localparam int PL = L - 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    req_type, slot;
   logic [PL-1:0] req_payload;
   logic          init_req_out;
   logic [L-1:0]  auth_msg_req_out;
   logic [7:0]    bmRequestType, bRequest;
   logic [15:0]   wLength;
   logic          Ack_in, resp_valid_in;
   logic [L-1:0]  auth_msg_resp_in;
   logic          busy, done;
   logic [2:0]    error_code;
   logic [31:0]   resp_header;
   logic [PL-1:0] resp_payload;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   auth_initiator #(.MSG_LEN(L), .MAX_RETRY(2)) dut (
      .clk(clk), .reset(reset), .start(start), .req_type(req_type), .slot(slot),
      .req_payload(req_payload), .init_req_out(init_req_out),
      .auth_msg_req_out(auth_msg_req_out), .bmRequestType(bmRequestType),
      .bRequest(bRequest), .wLength(wLength), .Ack_in(Ack_in),
      .resp_valid_in(resp_valid_in), .auth_msg_resp_in(auth_msg_resp_in),
      .busy(busy), .done(done), .error_code(error_code),
      .resp_header(resp_header), .resp_payload(resp_payload)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] rt, input logic [1:0] sl, input logic [63:0] pl);
      req_type    = rt;
      slot        = sl;
      req_payload = PL'(pl);
      start       = 1'b1;
      tick(1);
      start       = 1'b0;
   endtask

   task automatic ack();
      Ack_in = 1'b1;
      tick(1);
      Ack_in = 1'b0;
   endtask

   task automatic respond(input logic [31:0] hdr, input logic [63:0] pl);
      logic [PL-1:0] p;
      p                = PL'(pl);
      auth_msg_resp_in = {hdr, p};
      resp_valid_in    = 1'b1;
      tick(1);
      resp_valid_in    = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; req_type = '0; slot = '0; req_payload = '0;
      Ack_in = 1'b0; resp_valid_in = 1'b0; auth_msg_resp_in = '0;
      tick(2);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", error_code, 0);
      chk("rst_init", init_req_out, 0);
      chk("rst_msg_hdr", auth_msg_req_out[L-1:L-32], 0);
      chk("rst_resp_hdr", resp_header, 0);
      reset = 1'b0;

      // Digests, slot 1; start honoured on the first edge after reset release
      launch(2'd0, 2'd1, 64'hA5A5);
      chk("dig_init", init_req_out, 1);
      chk("dig_busy", busy, 1);
      chk("dig_hdr", auth_msg_req_out[L-1:L-32], 32'h01810100);
      chk("dig_wlen", wLength, 4);
      chk("dig_bmreq", bmRequestType, 8'h00);
      chk("dig_breq", bRequest, 8'd25);
      chk("dig_payload", auth_msg_req_out[63:0], 64'hA5A5);
      // Response strobe outside WAIT_RESP must not be captured
      auth_msg_resp_in = {32'h01010100, PL'(64'h77)};
      resp_valid_in = 1'b1;
      tick(3);
      resp_valid_in = 1'b0;
      chk("dig_wait_ack_init", init_req_out, 1);
      chk("dig_ignored_resp", resp_header, 0);
      ack();
      chk("dig_wait_init", init_req_out, 0);
      chk("dig_wait_busy", busy, 1);
      respond(32'h01010100, 64'hBEEF);
      chk("dig_resp_hdr", resp_header, 32'h01010100);
      chk("dig_resp_pl", resp_payload[63:0], 64'hBEEF);
      chk("dig_check_done", done, 0);
      tick(1);
      chk("dig_done", done, 1);
      chk("dig_err", error_code, 0);
      tick(1);
      chk("dig_idle_done", done, 0);
      chk("dig_idle_busy", busy, 0);
      chk("dig_hold_hdr", resp_header, 32'h01010100);

      // Challenge timeout
      launch(2'd2, 2'd0, 64'h1111_2222);
      chk("chl_hdr", auth_msg_req_out[L-1:L-32], 32'h01830000);
      chk("chl_wlen", wLength, 36);
      ack();
      tick(32'(CHALLENGE_TIMEOUT_AUTH) - 1);
      chk("chl_pre_done", done, 0);
      chk("chl_pre_busy", busy, 1);
      tick(1);
      chk("chl_done", done, 1);
      chk("chl_err", error_code, 1);
      tick(1);
      chk("chl_after_done", done, 0);
      chk("chl_err_hold", error_code, 1);

      // Certificate with two Busy retries then success
      launch(2'd1, 2'd2, 64'h5);
      chk("crt_init1", init_req_out, 1);
      chk("crt_hdr", auth_msg_req_out[L-1:L-32], 32'h01820200);
      chk("crt_wlen", wLength, 8);
      ack(); respond(32'h017F0300, 64'h0); tick(1);
      chk("crt_init2", init_req_out, 1);
      ack(); respond(32'h017F0300, 64'h0); tick(1);
      chk("crt_init3", init_req_out, 1);
      ack(); respond(32'h01020000, 64'hC0DE); tick(1);
      chk("crt_done", done, 1);
      chk("crt_err", error_code, 0);
      tick(1);

      // Three Busy responses exhaust the retries
      launch(2'd1, 2'd2, 64'h5);
      ack(); respond(32'h017F0300, 64'h0); tick(1);
      ack(); respond(32'h017F0300, 64'h0); tick(1);
      ack(); respond(32'h017F0300, 64'h0); tick(1);
      chk("busy3_done", done, 1);
      chk("busy3_err", error_code, 4);
      chk("busy3_init", init_req_out, 0);
      tick(1);

      // Bad version, unexpected type, invalid request
      launch(2'd0, 2'd0, 64'h0);
      ack(); respond(32'h02010100, 64'h0); tick(1);
      chk("ver_done", done, 1);
      chk("ver_err", error_code, 2);
      tick(1);
      launch(2'd0, 2'd0, 64'h0);
      ack(); respond(32'h01030000, 64'h0); tick(1);
      chk("type_done", done, 1);
      chk("type_err", error_code, 3);
      tick(1);
      launch(2'd3, 2'd0, 64'h0);
      chk("inv_done", done, 1);
      chk("inv_err", error_code, 5);
      chk("inv_init", init_req_out, 0);
      tick(1);
      chk("inv_idle_done", done, 0);
      chk("inv_err_hold", error_code, 5);
      chk("inv_idle_busy", busy, 0);

      // Asynchronous reset while in WAIT_RESP
      launch(2'd0, 2'd3, 64'h9);
      ack();
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_init", init_req_out, 0);
      chk("arst_done", done, 0);
      chk("arst_err", error_code, 0);
      chk("arst_resp_hdr", resp_header, 0);
      tick(1);
      reset = 1'b0;
      launch(2'd0, 2'd3, 64'h9);
      chk("post_rst_init", init_req_out, 1);
      chk("post_rst_hdr", auth_msg_req_out[L-1:L-32], 32'h01810300);
      ack(); respond(32'h01010100, 64'h0); tick(1);
      chk("post_rst_done", done, 1);
      chk("post_rst_err", error_code, 0);
      tick(1);

      // Response on the final timeout cycle wins
      launch(2'd0, 2'd0, 64'h0);
      ack();
      tick(32'(DIGEST_ANW_TIMEOUT) - 1);
      chk("coin_busy", busy, 1);
      chk("coin_nodone", done, 0);
      respond(32'h01010100, 64'hFACE);
      chk("coin_hdr", resp_header, 32'h01010100);
      tick(1);
      chk("coin_done", done, 1);
      chk("coin_err", error_code, 0);
      tick(1);

      // Ack_in in IDLE is ignored
      Ack_in = 1'b1;
      tick(1);
      Ack_in = 1'b0;
      chk("idle_ack_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/auth_initiator.md
AUTH_INITIATOR -- requirements
Module: auth_initiator

Interface
REQ-001 SHALL have parameter MSG_LEN, default 1024, full auth message width in bits (32-bit header plus payload).
REQ-002 SHALL have parameter MAX_RETRY, default 2, maximum resends after a Busy error response.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request launch, sampled only in IDLE.
REQ-006 SHALL have ports req_type  in  2 (0 GET_DIGESTS, 1 GET_CERTIFICATE, 2 CHALLENGE, 3 invalid) and slot  in  2 (Param1).
REQ-007 SHALL have port req_payload  in  MSG_LEN-32  request payload: certificate offset/length or challenge nonce.
REQ-008 SHALL have ports init_req_out  out  1 (request valid) and auth_msg_req_out  out  MSG_LEN (header in MSBs, then payload).
REQ-009 SHALL have ports bmRequestType  out  8, bRequest  out  8 and wLength  out  16  USB control-transfer fields for the request.
REQ-010 SHALL have port Ack_in  in  1  transport accepted the request.
REQ-011 SHALL have ports resp_valid_in  in  1 and auth_msg_resp_in  in  MSG_LEN  response strobe and message from the responder.
REQ-012 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), error_code  out  3, resp_header  out  32 and resp_payload  out  MSG_LEN-32.

Function
REQ-013 Header byte order, MSB first: ProtocolVersion=1, MessageType, Param1=slot, Param2=0.
REQ-014 Request MessageType SHALL be 0x81/0x82/0x83; expected response type 0x01/0x02/0x03; 0x7F is ERROR.
REQ-015 USB fields SHALL be bmRequestType=0x00, bRequest=25; wLength=4 (digests), 8 (certificate), 36 (challenge).
REQ-016 FSM states SHALL be IDLE, SEND_REQ, WAIT_RESP, CHECK_RESP, DONE, one-hot encoded.
REQ-017 IDLE: start=1 with req_type 0..2 SHALL latch req_type, slot, req_payload, clear the retry count, and enter SEND_REQ next cycle; busy=1 in every state except IDLE.
REQ-018 IDLE: start=1 with req_type=3 SHALL go to DONE with error_code=5 and SHALL NOT assert init_req_out.
REQ-019 SEND_REQ: init_req_out=1 and message/USB fields stable; Ack_in=1 SHALL go to WAIT_RESP and clear the timeout counter.
REQ-020 WAIT_RESP: the counter SHALL increment each cycle; the limit SHALL be DIGEST_ANW_TIMEOUT, CERTIFICATE_ANW_TIMEOUT or CHALLENGE_TIMEOUT_AUTH per req_type.
REQ-021 WAIT_RESP: resp_valid_in=1 SHALL capture auth_msg_resp_in into resp_header/resp_payload and go to CHECK_RESP.
REQ-022 Counter reaching limit-1 with no response SHALL go to DONE with error_code=1; if resp_valid_in coincides with that cycle, the response SHALL win.
REQ-023 CHECK_RESP (1 cycle): version!=1 SHALL give code 2; type==expected SHALL give code 0; type 0x7F SHALL follow REQ-024; any other type SHALL give code 3.
REQ-024 ERROR with Param1=0x03 (Busy) and retries<MAX_RETRY SHALL increment retries and return to SEND_REQ; otherwise code 4.
REQ-025 DONE SHALL pulse done=1 for exactly one cycle and return to IDLE; error_code and resp_* SHALL hold until the next start.
REQ-026 start SHALL be ignored outside IDLE; Ack_in outside SEND_REQ and resp_valid_in outside WAIT_RESP SHALL be ignored.

Reset
REQ-027 reset=1 SHALL asynchronously force IDLE, clear counters, and clear every output to 0 (error_code=0, init_req_out=0, done=0, busy=0), including mid-transaction.
REQ-028 After reset deassertion, the first start SHALL be honoured on the first posedge.

Structure
REQ-029 MSG_LEN, header field size, MessageType codes, error codes, and the three timeout constants (in cycles) SHALL live in the shared authentication package.
REQ-030 A sub-module auth_req_builder SHALL form header, payload and USB fields combinationally from the latched request; the FSM and counters SHALL stay in auth_initiator.

Verification
REQ-031 Digests: start, req_type=0, slot=1; Ack_in after 3 cycles; response header 0x01010100 -> header 0x01810100, wLength=4, done with error_code=0.
REQ-032 Challenge timeout: req_type=2; Ack_in; no response -> done exactly CHALLENGE_TIMEOUT_AUTH cycles after WAIT_RESP entry, error_code=1.
REQ-033 Busy retry: req_type=1; respond 0x017F0300 twice, then 0x01020000 -> three init_req_out assertions, error_code=0; a third Busy gives error_code=4.
REQ-034 Bad response: version 0x02 -> code 2; type 0x03 returned to a GET_DIGESTS request -> code 3; req_type=3 -> code 5 with no init_req_out.
REQ-035 Reset in WAIT_RESP: assert reset -> outputs 0 at once; a following start runs a clean transaction.
REQ-036 Coincidence: resp_valid_in on the final timeout cycle -> response accepted, error_code=0.
